// File: rtl/mips_pkg.sv
// mips_pkg: definitions shared between the execute stage and the HI/LO
// multiply/divide sequencer.
//   - op encodings for the mul/div/move-to-HI/LO operations
//   - FSM state type for the sequencer
//   - iteration count for one mul/div
//   - small decode helpers for op codes
package mips_pkg;

  localparam int MULDIV_ITER = 32;

  localparam logic [2:0] OP_MULT  = 3'd0;
  localparam logic [2:0] OP_MULTU = 3'd1;
  localparam logic [2:0] OP_DIV   = 3'd2;
  localparam logic [2:0] OP_DIVU  = 3'd3;
  localparam logic [2:0] OP_MTHI  = 3'd4;
  localparam logic [2:0] OP_MTLO  = 3'd5;

  typedef enum logic [1:0] {
    IDLE,
    PREP,
    RUN,
    FIX
  } muldiv_state_t;

  // True for the four ops that run the iterative datapath.
  function automatic logic is_muldiv(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == OP_DIV) || (op == OP_DIVU);
  endfunction

  function automatic logic is_signed_op(input logic [2:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/muldiv_step.sv
// muldiv_step: one combinational iteration of the unsigned mul/div datapath.
// Ports:
//   is_div   in   select restoring-divide step (1) or shift-add multiply step (0)
//   hi_in    in   upper accumulator (product high half / partial remainder)
//   lo_in    in   lower accumulator (multiplier bits / dividend-quotient bits)
//   operand  in   multiplicand or divisor (already a magnitude)
//   hi_out   out  next upper accumulator
//   lo_out   out  next lower accumulator
module muldiv_step #(
  parameter int WIDTH = 32
) (
  input  logic             is_div,
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] operand,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] addend;
  logic [WIDTH:0] rem_shift;
  logic [WIDTH:0] diff;
  logic           fits;

  always_comb begin
    // Multiply: conditional add keeps its carry in bit WIDTH, which the right
    // shift moves back into the upper half, so the upper half never overflows.
    addend = lo_in[0] ? ({1'b0, hi_in} + {1'b0, operand}) : {1'b0, hi_in};

    // Divide: the partial remainder is always below the divisor, so after the
    // left shift it is below twice the divisor and the subtraction result's
    // top bit acts as the borrow.
    rem_shift = {hi_in, lo_in[WIDTH-1]};
    diff      = rem_shift - {1'b0, operand};
    fits      = ~diff[WIDTH];

    if (is_div) begin
      hi_out = fits ? diff[WIDTH-1:0] : rem_shift[WIDTH-1:0];
      lo_out = {lo_in[WIDTH-2:0], fits};
    end else begin
      hi_out = addend[WIDTH:1];
      lo_out = {addend[0], lo_in[WIDTH-1:1]};
    end
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// hilo_muldiv_ctrl: multi-cycle multiply/divide sequencer that owns HI/LO.
// Ports:
//   clk, reset        clock and asynchronous active-high reset
//   start, op, a, b   issue request (sampled only while idle), op code, operands
//   flush             abort the in-flight mul/div; also drops a same-cycle start
//   rd_hilo           execute stage wants HI/LO this cycle
//   busy, stall       mul/div in flight; stall = rd_hilo & busy
//   done              one-cycle pulse after HI/LO were written by a mul/div
//   hi, lo            architectural HI/LO registers
module hilo_muldiv_ctrl
  import mips_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int ITER  = MULDIV_ITER
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  input  logic             rd_hilo,
  output logic             busy,
  output logic             stall,
  output logic             done,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(ITER);

  muldiv_state_t state, state_next;

  logic             is_div_r, signed_r, neg_res, neg_rem, div_zero;
  logic [WIDTH-1:0] acc_hi, acc_lo, operand;
  logic [WIDTH-1:0] step_hi, step_lo;
  logic [CW-1:0]    cnt;

  logic [2*WIDTH-1:0] prod;
  logic [WIDTH-1:0]   quo, rem, fix_hi, fix_lo;

  muldiv_step #(.WIDTH(WIDTH)) u_step (
    .is_div  (is_div_r),
    .hi_in   (acc_hi),
    .lo_in   (acc_lo),
    .operand (operand),
    .hi_out  (step_hi),
    .lo_out  (step_lo)
  );

  assign busy  = (state != IDLE);
  assign stall = rd_hilo & busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Flush overrides everything: it aborts a busy sequence and blocks a new
  // issue in the same idle cycle. Divide by zero skips straight to FIX.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (start && is_muldiv(op))
              state_next = (is_div_op(op) && (b == '0)) ? FIX : PREP;
      PREP: state_next = RUN;
      RUN:  if (cnt == CW'(ITER - 1)) state_next = FIX;
      FIX:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
    if (flush) state_next = IDLE;
  end

  // Signed correction applied to the unsigned magnitude result in FIX.
  always_comb begin
    prod = {acc_hi, acc_lo};
    if (signed_r && neg_res) prod = -prod;
    quo = acc_lo;
    if (signed_r && neg_res) quo = -quo;
    rem = acc_hi;
    if (signed_r && neg_rem) rem = -rem;

    if (div_zero) begin
      fix_hi = acc_lo;
      fix_lo = '1;
    end else if (is_div_r) begin
      fix_hi = rem;
      fix_lo = quo;
    end else begin
      fix_hi = prod[2*WIDTH-1:WIDTH];
      fix_lo = prod[WIDTH-1:0];
    end
  end

  // Multiply keeps the multiplier in acc_lo and the multiplicand in operand;
  // divide keeps the dividend in acc_lo and the divisor in operand. For a
  // zero divisor acc_lo still holds the raw dividend, which becomes HI.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hi       <= '0;
      lo       <= '0;
      done     <= 1'b0;
      acc_hi   <= '0;
      acc_lo   <= '0;
      operand  <= '0;
      cnt      <= '0;
      is_div_r <= 1'b0;
      signed_r <= 1'b0;
      neg_res  <= 1'b0;
      neg_rem  <= 1'b0;
      div_zero <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start && !flush) begin
            if (op == OP_MTHI) hi <= a;
            if (op == OP_MTLO) lo <= a;
            if (is_muldiv(op)) begin
              is_div_r <= is_div_op(op);
              signed_r <= is_signed_op(op);
              neg_res  <= a[WIDTH-1] ^ b[WIDTH-1];
              neg_rem  <= a[WIDTH-1];
              div_zero <= is_div_op(op) && (b == '0);
              acc_hi   <= '0;
              acc_lo   <= is_div_op(op) ? a : b;
              operand  <= is_div_op(op) ? b : a;
            end
          end
        end
        PREP: begin
          acc_lo <= (signed_r && acc_lo[WIDTH-1]) ? -acc_lo : acc_lo;
          operand <= (signed_r && operand[WIDTH-1]) ? -operand : operand;
          acc_hi <= '0;
          cnt    <= '0;
        end
        RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
        end
        FIX: begin
          if (!flush) begin
            hi   <= fix_hi;
            lo   <= fix_lo;
            done <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
